// File: rtl/i2s_tx.sv
// ============================================================================
// i2s_tx -- stereo I2S transmitter
//
// Serializes signed parallel stereo samples into a standard I2S stream
// (one-BCLK data delay after each LRCLK edge, MSB first). BCLK, LRCLK and
// SDATA are all derived from the single system clock and are registered.
// One stereo pair is taken per frame through a valid/ready handshake backed
// by a one-entry holding buffer. When no pair is available at a frame
// boundary the frame carries silence and a one-cycle underrun pulse is raised.
//
// Ports:
//   clk       in   system clock, all logic on the rising edge
//   rst_n     in   asynchronous active-low reset
//   left_in   in   left-channel sample (signed, DATA_W bits)
//   right_in  in   right-channel sample (signed, DATA_W bits)
//   in_valid  in   left_in/right_in hold a valid pair
//   in_ready  out  holding buffer empty; transfer when in_valid && in_ready
//   bclk      out  I2S bit clock (BCLK_DIV clk cycles per period, 50% duty)
//   lrclk     out  word select, 0 = left slot, 1 = right slot
//   sdata     out  serial data, MSB first, changes as bclk falls
//   underrun  out  one-clk pulse when a frame is loaded with no sample
// ============================================================================
module i2s_tx #(
   parameter int DATA_W   = 24,  // sample width, >= 2
   parameter int SLOT_W   = 32,  // BCLK periods per channel slot, >= DATA_W+1
   parameter int BCLK_DIV = 4    // clk cycles per BCLK period, even, >= 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] left_in,
   input  logic [DATA_W-1:0] right_in,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              bclk,
   output logic              lrclk,
   output logic              sdata,
   output logic              underrun
);

   localparam int DIV_W = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
   localparam int BIT_W = $clog2(2 * SLOT_W);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIV / 2);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_W - 1);
   localparam logic [BIT_W-1:0] BIT_SLOT = BIT_W'(SLOT_W);

   // Timing state
   logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
   logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;

   // Holding buffer; in_ready_q doubles as its "empty" flag
   logic [DATA_W-1:0] buf_l_q, buf_l_d;
   logic [DATA_W-1:0] buf_r_q, buf_r_d;
   logic              in_ready_q, in_ready_d;

   // Frame register (pair being transmitted) and channel shifter
   logic [DATA_W-1:0] frame_l_q, frame_l_d;
   logic [DATA_W-1:0] frame_r_q, frame_r_d;
   logic [DATA_W-1:0] shift_q, shift_d;

   // Registered outputs
   logic              bclk_q, bclk_d;
   logic              lrclk_q, lrclk_d;
   logic              sdata_q, sdata_d;
   logic              underrun_q, underrun_d;

   logic              div_wrap;
   logic              load;

   always_comb begin
      // NOTE: every signal assigned in this block gets a default first, so no
      // path can leave it unassigned and infer a latch.
      div_cnt_d  = div_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      buf_l_d    = buf_l_q;
      buf_r_d    = buf_r_q;
      in_ready_d = in_ready_q;
      frame_l_d  = frame_l_q;
      frame_r_d  = frame_r_q;
      shift_d    = shift_q;
      lrclk_d    = lrclk_q;
      sdata_d    = sdata_q;
      underrun_d = 1'b0;

      // BCLK divider; the wrap edge is the BCLK falling edge
      div_wrap  = (div_cnt_q == DIV_LAST);
      div_cnt_d = div_wrap ? '0 : div_cnt_q + DIV_W'(1);
      bclk_d    = (div_cnt_d >= DIV_HALF);

      // Load cycle: last clk of the last bit of the frame
      load = div_wrap && (bit_cnt_q == BIT_LAST);

      if (div_wrap) begin
         bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + BIT_W'(1);
      end

      // Frame loading and handshake. In the load cycle a full buffer wins;
      // an empty buffer lets a simultaneous input pair bypass straight in.
      if (load) begin
         if (!in_ready_q) begin
            frame_l_d  = buf_l_q;
            frame_r_d  = buf_r_q;
            in_ready_d = 1'b1;
         end else if (in_valid) begin
            frame_l_d = left_in;
            frame_r_d = right_in;
         end else begin
            frame_l_d  = '0;
            frame_r_d  = '0;
            underrun_d = 1'b1;
         end
      end else if (in_valid && in_ready_q) begin
         buf_l_d    = left_in;
         buf_r_d    = right_in;
         in_ready_d = 1'b0;
      end

      // Serializer. At each slot start (k=0) the delay bit is 0 and the
      // channel is loaded into the shifter; after DATA_W shifts the shifter
      // holds only zeros, which provides the trailing padding for free.
      if (div_wrap) begin
         lrclk_d = (bit_cnt_d >= BIT_SLOT);
         if (bit_cnt_d == '0) begin
            sdata_d = 1'b0;
            shift_d = frame_l_d;
         end else if (bit_cnt_d == BIT_SLOT) begin
            sdata_d = 1'b0;
            shift_d = frame_r_q;
         end else begin
            sdata_d = shift_q[DATA_W-1];
            shift_d = {shift_q[DATA_W-2:0], 1'b0};
         end
      end
   end

   // NOTE: state is updated with non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the buffer and frame data are reset as well, so a pair held
         // when reset hits can never leak into the stream afterwards.
         div_cnt_q  <= '0;
         bit_cnt_q  <= '0;
         buf_l_q    <= '0;
         buf_r_q    <= '0;
         in_ready_q <= 1'b1;
         frame_l_q  <= '0;
         frame_r_q  <= '0;
         shift_q    <= '0;
         bclk_q     <= 1'b0;
         lrclk_q    <= 1'b0;
         sdata_q    <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         div_cnt_q  <= div_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         buf_l_q    <= buf_l_d;
         buf_r_q    <= buf_r_d;
         in_ready_q <= in_ready_d;
         frame_l_q  <= frame_l_d;
         frame_r_q  <= frame_r_d;
         shift_q    <= shift_d;
         bclk_q     <= bclk_d;
         lrclk_q    <= lrclk_d;
         sdata_q    <= sdata_d;
         underrun_q <= underrun_d;
      end
   end

   assign in_ready = in_ready_q;
   assign bclk     = bclk_q;
   assign lrclk    = lrclk_q;
   assign sdata    = sdata_q;
   assign underrun = underrun_q;

endmodule

// File: tb/tb_i2s_tx.sv
// ============================================================================
// tb_i2s_tx -- self-checking bench for i2s_tx
//
// A cycle-indexed reference model derives every output from the cycle number
// since reset release: bclk/lrclk/bit position by plain division, sdata from
// the pair the model decided each frame carries. Directed scenarios plus
// randomized pairs and gaps drive the input handshake.
// ============================================================================
module tb_i2s_tx;

   localparam int DATA_W   = 24;
   localparam int SLOT_W   = 32;
   localparam int BCLK_DIV = 4;
   localparam int FRAME    = 2 * SLOT_W * BCLK_DIV;
   localparam int BUDGET   = 4 * FRAME;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [DATA_W-1:0] left_in = '0;
   logic [DATA_W-1:0] right_in = '0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic              bclk;
   logic              lrclk;
   logic              sdata;
   logic              underrun;

   int n_checks = 0;
   int n_fail   = 0;

   i2s_tx #(
      .DATA_W  (DATA_W),
      .SLOT_W  (SLOT_W),
      .BCLK_DIV(BCLK_DIV)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .left_in (left_in),
      .right_in(right_in),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .bclk    (bclk),
      .lrclk   (lrclk),
      .sdata   (sdata),
      .underrun(underrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------------
   // Reference model: cyc = rising edges since reset release, so during
   // cycle cyc the outputs reflect cyc edges of activity.
   // ------------------------------------------------------------------------
   int unsigned       cyc = 0;
   bit                m_full = 1'b0;
   bit                m_underrun = 1'b0;
   logic [DATA_W-1:0] m_buf_l = '0, m_buf_r = '0;
   logic [DATA_W-1:0] m_cur_l = '0, m_cur_r = '0;

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         cyc        = 0;
         m_full     = 1'b0;
         m_underrun = 1'b0;
         m_buf_l    = '0;
         m_buf_r    = '0;
         m_cur_l    = '0;
         m_cur_r    = '0;
      end else begin
         m_underrun = 1'b0;
         if (cyc % FRAME == FRAME - 1) begin
            if (m_full) begin
               m_cur_l = m_buf_l;
               m_cur_r = m_buf_r;
               m_full  = 1'b0;
            end else if (in_valid) begin
               m_cur_l = left_in;
               m_cur_r = right_in;
            end else begin
               m_cur_l    = '0;
               m_cur_r    = '0;
               m_underrun = 1'b1;
            end
         end else if (in_valid && !m_full) begin
            m_buf_l = left_in;
            m_buf_r = right_in;
            m_full  = 1'b1;
         end
         cyc++;
      end
   end

   // Per-cycle comparison on the falling clk edge, away from the active edge
   initial forever begin
      @(negedge clk);
      if (rst_n) begin
         int p, k;
         logic [DATA_W-1:0] ch;
         logic exp_sd;
         p      = int'((cyc / BCLK_DIV) % (2 * SLOT_W));
         k      = p % SLOT_W;
         ch     = (p < SLOT_W) ? m_cur_l : m_cur_r;
         exp_sd = (k >= 1 && k <= DATA_W) ? ch[DATA_W-k] : 1'b0;
         check("bclk",     32'(bclk),     32'((cyc % BCLK_DIV) >= BCLK_DIV / 2));
         check("lrclk",    32'(lrclk),    32'(p >= SLOT_W));
         check("sdata",    32'(sdata),    32'(exp_sd));
         check("in_ready", 32'(in_ready), 32'(!m_full));
         check("underrun", 32'(underrun), 32'(m_underrun));
      end
   end

   // ------------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------------
   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Return #1 after the edge that starts the cycle with cyc % FRAME == ph
   task automatic wait_phase(input int ph);
      int guard = 0;
      while (cyc % FRAME != ph) begin
         @(posedge clk);
         #1;
         guard++;
         if (guard > BUDGET) begin
            check("wait_phase_timeout", 32'(guard), 32'(0));
            return;
         end
      end
   endtask

   // Present a pair and hold it until the handshake completes
   task automatic send(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r, input bit keep);
      logic rdy;
      int   guard = 0;
      left_in  = l;
      right_in = r;
      in_valid = 1'b1;
      forever begin
         @(negedge clk);
         rdy = in_ready;
         @(posedge clk);
         if (rdy) break;
         guard++;
         if (guard > BUDGET) begin
            check("send_timeout", 32'(guard), 32'(0));
            break;
         end
      end
      #1;
      if (!keep) in_valid = 1'b0;
   endtask

   // Deserialize one frame from the pins (call at the start of a frame)
   task automatic capture_frame(output logic [DATA_W-1:0] l, output logic [DATA_W-1:0] r);
      l = '0;
      r = '0;
      for (int i = 0; i < FRAME; i++) begin
         @(negedge clk);
         if (cyc % BCLK_DIV == BCLK_DIV / 2) begin
            int p, k;
            p = int'((cyc / BCLK_DIV) % (2 * SLOT_W));
            k = p % SLOT_W;
            if (k >= 1 && k <= DATA_W) begin
               if (p < SLOT_W) l = {l[DATA_W-2:0], sdata};
               else            r = {r[DATA_W-2:0], sdata};
            end
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------------------
   // Scenarios
   // ------------------------------------------------------------------------
   initial begin
      logic [DATA_W-1:0] cap_l, cap_r;
      int cnt;

      // Reset and idle outputs
      #22;
      check("rst_bclk",     32'(bclk),     32'(0));
      check("rst_lrclk",    32'(lrclk),    32'(0));
      check("rst_sdata",    32'(sdata),    32'(0));
      check("rst_underrun", 32'(underrun), 32'(0));
      check("rst_in_ready", 32'(in_ready), 32'(1));
      rst_n = 1'b1;

      // Single pair accepted mid first frame, sent in the second frame
      wait_cycles(2);
      wait_phase(100);
      send(24'h400000, 24'hC00000, 1'b0);
      wait_phase(0);
      capture_frame(cap_l, cap_r);
      check("single_left",  32'(cap_l), 32'h400000);
      check("single_right", 32'(cap_r), 32'hC00000);

      // Two idle frames: one underrun pulse after each load
      cnt = 0;
      for (int i = 0; i < 2 * FRAME; i++) begin
         @(negedge clk);
         cnt += int'(underrun);
      end
      check("underrun_pulses", 32'(cnt), 32'(2));

      // Back-to-back with in_valid held high
      wait_phase(10);
      send(24'h000000, 24'h000000, 1'b1);
      send(24'h100000, 24'h100000, 1'b1);
      send(24'h800000, 24'h800000, 1'b1);
      send(24'hF00000, 24'hF00000, 1'b0);
      wait_cycles(3 * FRAME);

      // Bypass: in_valid first asserted in the load cycle, buffer empty
      wait_phase(FRAME - 1);
      left_in  = 24'h123456;
      right_in = 24'hABCDEF;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      cnt = 0;
      capture_frame(cap_l, cap_r);
      check("bypass_left",  32'(cap_l), 32'h123456);
      check("bypass_right", 32'(cap_r), 32'hABCDEF);

      // Randomized pairs and gaps
      for (int i = 0; i < 8; i++) begin
         wait_cycles(int'($urandom_range(0, 300)));
         send(DATA_W'($urandom()), DATA_W'($urandom()), 1'b0);
      end
      wait_cycles(3 * FRAME);

      // Reset in the right slot with the buffer full
      wait_phase(10);
      send(24'h7FFFFF, 24'h555555, 1'b0);
      wait_phase(200);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_bclk",     32'(bclk),     32'(0));
      check("mid_rst_lrclk",    32'(lrclk),    32'(0));
      check("mid_rst_sdata",    32'(sdata),    32'(0));
      check("mid_rst_underrun", 32'(underrun), 32'(0));
      check("mid_rst_in_ready", 32'(in_ready), 32'(1));
      #20;
      rst_n = 1'b1;
      cnt = 0;
      for (int i = 0; i < 2 * FRAME; i++) begin
         @(negedge clk);
         cnt += int'(sdata);
      end
      check("post_rst_silence", 32'(cnt), 32'(0));
      wait_cycles(4);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
- Stereo I2S transmitter that serializes signed parallel audio samples from the equalizer output path toward an external DAC.
- Generates BCLK, LRCLK and SDATA from the single system clock.
- Accepts one stereo sample pair per frame through a valid/ready handshake, using a one-entry holding buffer.
- Transmits silence and flags underrun when no sample is available at a frame boundary.

Parameters:
- DATA_W, 24, sample width, signed two's complement.
- SLOT_W, 32, BCLK periods per channel slot; must be >= DATA_W+1.
- BCLK_DIV, 4, clk cycles per BCLK period; must be even and >= 2.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- left_in  input  DATA_W  left-channel sample, signed.
- right_in  input  DATA_W  right-channel sample, signed.
- in_valid  input  1  left_in/right_in hold a valid pair.
- in_ready  output  1  holding buffer empty; transfer occurs when in_valid && in_ready.
- bclk  output  1  I2S bit clock.
- lrclk  output  1  word select; 0 = left, 1 = right.
- sdata  output  1  serial data, MSB first.
- underrun  output  1  one-clk pulse when a frame is loaded with no sample available.

Behaviour:
- Reset (async, rst_n=0): bclk=0, lrclk=0, sdata=0, underrun=0, in_ready=1. Holding buffer is cleared and its contents discarded. div_cnt=0, bit_cnt=0, frame register=0.
- div_cnt counts 0..BCLK_DIV-1 and wraps. bclk=0 while div_cnt<BCLK_DIV/2, else 1. All outputs are registered.
- Fall event: the clk edge at which div_cnt wraps to 0, i.e. bclk goes low. On each fall event:
  - bit_cnt p advances 0..2*SLOT_W-1 and wraps.
  - lrclk and sdata update on the same clk edge as bclk falls.
- lrclk = (p >= SLOT_W).
- sdata, with k = p mod SLOT_W:
  - k=0: 0 (one-BCLK I2S delay).
  - k=1..DATA_W: channel bit DATA_W-k, so the MSB is sent at k=1.
  - k>DATA_W: 0.
  - Channel is left when p<SLOT_W, right otherwise.
- Load cycle: the cycle with div_cnt==BCLK_DIV-1 and bit_cnt==2*SLOT_W-1, i.e. the cycle before a frame starts. In the load cycle:
  - Buffer full: frame register takes the buffered pair; buffer empties; in_ready=1 from the next cycle.
  - Buffer empty and in_valid=1 (in_ready=1): bypass. Frame register takes left_in/right_in directly, buffer stays empty, no underrun.
  - Buffer empty and in_valid=0: frame register is loaded with zeros; underrun=1 for exactly the next clk cycle.
- The first frame after reset is always silent with no underrun pulse; the first load cycle occurs at the end of that frame.
- Handshake:
  - in_ready = buffer empty, registered.
  - A transfer outside the load cycle fills the buffer; in_ready drops on the next cycle.
  - While in_ready=0, in_valid is ignored; the source holds its data.
  - At most one pair is accepted per frame in steady state. No pair is ever dropped or duplicated.
- Arithmetic: none. Data is transmitted bit-exact; the sign bit is the MSB.
- Frame length is 2*SLOT_W*BCLK_DIV clk cycles (256 with defaults).
- Reset mid-frame: all outputs go to reset values immediately. After release, a silent first frame restarts from p=0.

Test Plan:
- Reset/clock check: rst_n low for 20 ns -> all outputs 0, in_ready=1. After release, bclk period 4 clk at 50% duty; lrclk period 256 clk, low for the first 128; first frame sdata all 0; underrun never asserted.
- Single pair: left=24'h400000, right=24'hC00000 accepted mid first frame -> second frame:
  - left k=1..24 = 0100_0000..0, right k=1..24 = 1100_0000..0.
  - k=0 and k=25..31 are 0 in both slots.
  - in_ready=1 again the cycle after the load.
- Underrun: no in_valid after the first pair -> the following frame is all zeros, with a 1-clk underrun pulse right after each load cycle.
- Back-to-back: in_valid held high with 24'h000000, 24'h100000, 24'h800000, 24'hF00000 -> one pair accepted per frame, in_ready low while the buffer is full, frames carry the values in order, 24'h800000 sends MSB=1 then 23 zeros, no underrun.
- Bypass: in_valid first asserted exactly in the load cycle with the buffer empty -> that pair is sent in the next frame, no underrun pulse, in_ready stays 1.
- Reset mid-operation: rst_n low during the right slot with the buffer full -> bclk/lrclk/sdata=0 at once. After release, silent frame, the buffered pair is never transmitted, and in_ready=1.
